// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding,
// access-width codes and the alignment predicate.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;

  // Code 11 is treated as a word access.
  function automatic logic misaligned(
    input logic [1:0] addr_lo,
    input logic [1:0] width
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      (width == WIDTH_BYTE): bad = 1'b0;
      (width == WIDTH_HALF): bad = addr_lo[0];
      default:               bad = |addr_lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and data memory.
// slave: arbiter view. master: requester/memory (testbench) view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              m0_valid;
  logic              m0_ready;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_wen;
  logic [1:0]        m0_width;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_valid;
  logic              m1_ready;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_wen;
  logic [1:0]        m1_width;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic [1:0]        mem_width;
  logic [DATA_W-1:0] mem_dout;
  logic              err;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata,
    input  m0_wen, m0_width,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata,
    input  m1_wen, m1_width,
    output m1_ready, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_wen,
    output mem_width, err,
    input  mem_dout
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata,
    output m0_wen, m0_width,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_valid, m1_addr, m1_wdata,
    output m1_wen, m1_width,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_wen,
    input  mem_width, err,
    output mem_dout
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with its priority flop.
// Ports: clk, rst, i_en (arbitrate this cycle), i_req[1:0], o_grant[1:0].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  // 0: requester 0 holds priority, 1: requester 1 does.
  logic       r_prio;
  logic [1:0] w_pick;

  always_comb begin
    w_pick = 2'b00;
    unique case (1'b1)
      (i_req == 2'b11): w_pick = r_prio ? 2'b10 : 2'b01;
      default:          w_pick = i_req;
    endcase
  end

  assign o_grant = i_en ? w_pick : 2'b00;

  // Priority passes to whoever was not granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (|o_grant) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP per access.
// Ports: clk, rst (async, active-high), bus (dmem_arbiter_if.slave).
// Optional macro DMEM_ARB_ALIGN_CHK_EN enables misalignment checking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [1:0]        r_width;
  logic              r_id;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_idle;
  logic              w_bad;
  logic              w_mem_wen;
  logic              w_rv0;
  logic              w_rv1;
  logic              w_err;
  logic [DATA_W-1:0] w_ret;

  // Ready is also masked during reset so nothing is accepted then.
  assign w_idle   = (r_state == ST_IDLE) && !rst;
  assign w_accept = |w_grant;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_idle),
    .i_req   ({bus.m1_valid, bus.m0_valid}),
    .o_grant (w_grant)
  );

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign w_bad = misaligned(r_addr[1:0], r_width);
`else
  assign w_bad = 1'b0;
`endif

  // Stores and rejected accesses return zero.
  assign w_ret = (r_wen || w_bad) ? '0 : bus.mem_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_mem_wen = 1'b0;
    w_rv0     = 1'b0;
    w_rv1     = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_next    = ST_RESP;
        w_mem_wen = r_wen && !w_bad;
      end
      ST_RESP: begin
        w_next = ST_IDLE;
        w_rv0  = !r_id;
        w_rv1  = r_id;
        w_err  = w_bad;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_width <= WIDTH_WORD;
      r_id    <= 1'b0;
    end else if (w_accept) begin
      r_id <= w_grant[1];
      unique case (1'b1)
        w_grant[1]: begin
          r_addr  <= bus.m1_addr;
          r_wdata <= bus.m1_wdata;
          r_wen   <= bus.m1_wen;
          r_width <= bus.m1_width;
        end
        default: begin
          r_addr  <= bus.m0_addr;
          r_wdata <= bus.m0_wdata;
          r_wen   <= bus.m0_wen;
          r_width <= bus.m0_width;
        end
      endcase
    end
  end

  // Read data is captured at the end of ACCESS and held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (r_id) r_rdata1 <= w_ret;
      else      r_rdata0 <= w_ret;
    end
  end

  assign bus.m0_ready  = w_grant[0];
  assign bus.m1_ready  = w_grant[1];
  assign bus.m0_rvalid = w_rv0;
  assign bus.m1_rvalid = w_rv1;
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_width = r_width;
  assign bus.mem_wen   = w_mem_wen;
  assign bus.err       = w_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus
// hand-written reset-mid-access and withdrawn-request sequences.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] MS = 32'h12345678;
  localparam logic [31:0] EXP27 = CHK ? DB : MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [16];
  bit          mem_init = 1'b0;

  assign bus.mem_dout = mem[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
      mem_init <= 1'b1;
    end else if (bus.mem_wen) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic        v0, w0;
    logic [31:0] a0, d0;
    logic [1:0]  s0;
    logic        v1, w1;
    logic [31:0] a1, d1;
    logic [1:0]  s1;
    logic        r0, r1, wen, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        err;
    logic [1:0]  mw;
    logic [31:0] md;
  } vec_t;

  vec_t vq[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic v0, w0, input logic [31:0] a0, d0,
    input logic [1:0] s0,
    input logic v1, w1, input logic [31:0] a1, d1,
    input logic [1:0] s1,
    input logic r0, r1, wen, rv0, rv1,
    input logic [31:0] rd0, rd1,
    input logic err, input logic [1:0] mw,
    input logic [31:0] md);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.r0 = r0; v.r1 = r1; v.wen = wen;
    v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
    v.err = err; v.mw = mw; v.md = md;
    return v;
  endfunction

  task automatic set0(input logic v, w, input logic [31:0] a, d,
                      input logic [1:0] s);
    bus.m0_valid = v; bus.m0_wen = w; bus.m0_addr = a;
    bus.m0_wdata = d; bus.m0_width = s;
  endtask

  task automatic set1(input logic v, w, input logic [31:0] a, d,
                      input logic [1:0] s);
    bus.m1_valid = v; bus.m1_wen = w; bus.m1_addr = a;
    bus.m1_wdata = d; bus.m1_width = s;
  endtask

  task automatic chk_all(input string p, input vec_t v);
    chk({p, ".rdy0"},  32'(bus.m0_ready),  32'(v.r0));
    chk({p, ".rdy1"},  32'(bus.m1_ready),  32'(v.r1));
    chk({p, ".wen"},   32'(bus.mem_wen),   32'(v.wen));
    chk({p, ".rv0"},   32'(bus.m0_rvalid), 32'(v.rv0));
    chk({p, ".rv1"},   32'(bus.m1_rvalid), 32'(v.rv1));
    chk({p, ".rd0"},   bus.m0_rdata,       v.rd0);
    chk({p, ".rd1"},   bus.m1_rdata,       v.rd1);
    chk({p, ".err"},   32'(bus.err),       32'(v.err));
    chk({p, ".width"}, 32'(bus.mem_width), 32'(v.mw));
    chk({p, ".wdata"}, bus.mem_wdata,      v.md);
  endtask

  localparam logic [31:0] A0 = 32'h10000;
  localparam logic [31:0] A4 = 32'h10004;
  localparam logic [31:0] A8 = 32'h10008;

  initial begin
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);

    // m0 word store, then load-back
    vq.push_back(mk(1,1,A0,DB,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0,0, 0,0,1,0,0, 0,0,0,0,DB));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0,0, 0,0,0,1,0, 0,0,0,0,DB));
    vq.push_back(mk(1,0,A0,0,0,  0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,DB));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0,0, 0,0,0,1,0, DB,0,0,0,0));
    // m1 byte store
    vq.push_back(mk(0,0,0,0,0, 1,1,A4,32'hAB,2,
                    0,1,0,0,0, DB,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,1,0,0, DB,0,0,2,32'hAB));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,0,0,1, DB,0,0,2,32'hAB));
    // both held valid: m0, m1, m0, m1
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    1,0,0,0,0, DB,0,0,2,32'hAB));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,0,0, DB,0,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,1,0, 32'hAB,0,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,1,0,0,0, 32'hAB,0,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,0,0, 32'hAB,0,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,0,1, 32'hAB,DB,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    1,0,0,0,0, 32'hAB,DB,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,0,0, 32'hAB,DB,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,1,0, 32'hAB,DB,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,1,0,0,0, 32'hAB,DB,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,0,0, 32'hAB,DB,0,0,0));
    vq.push_back(mk(1,0,A4,0,0, 1,0,A0,0,0,
                    0,0,0,0,1, 32'hAB,DB,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,0,0,0, 32'hAB,DB,0,0,0));
    // misaligned word store to 0x10002
    vq.push_back(mk(1,1,32'h10002,MS,0, 0,0,0,0,0,
                    1,0,0,0,0, 32'hAB,DB,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,!CHK,0,0, 32'hAB,DB,0,0,MS));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,0,1,0, 0,DB,CHK,0,MS));
    vq.push_back(mk(1,0,A0,0,0, 0,0,0,0,0,
                    1,0,0,0,0, 0,DB,0,0,MS));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,0,0,0, 0,DB,0,0,0));
    vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0,
                    0,0,0,1,0, EXP27,DB,0,0,0));

    // reset state
    @(negedge clk);
    chk("rst.rdy0",  32'(bus.m0_ready),  0);
    chk("rst.wen",   32'(bus.mem_wen),   0);
    chk("rst.addr",  bus.mem_addr,       0);
    chk("rst.wdata", bus.mem_wdata,      0);
    chk("rst.width", 32'(bus.mem_width), 0);
    chk("rst.rd0",   bus.m0_rdata,       0);
    chk("rst.rd1",   bus.m1_rdata,       0);
    chk("rst.err",   32'(bus.err),       0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      set0(vq[i].v0, vq[i].w0, vq[i].a0, vq[i].d0, vq[i].s0);
      set1(vq[i].v1, vq[i].w1, vq[i].a1, vq[i].d1, vq[i].s1);
      #1;
      chk_all($sformatf("v%0d", i), vq[i]);
    end

    // request withdrawn before ready causes no access
    @(negedge clk);
    set0(1, 0, A4, 0, 0);
    set1(0, 0, 0, 0, 0);
    #1 chk("wd.rdy0", 32'(bus.m0_ready), 1);
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    set1(1, 1, 32'h1000C, 32'hBAD0BAD0, 0);
    #1 chk("wd.rdy1a", 32'(bus.m1_ready), 0);
    @(negedge clk);
    #1 chk("wd.rdy1b", 32'(bus.m1_ready), 0);
    chk("wd.rv0", 32'(bus.m0_rvalid), 1);
    set1(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("wd.wen%0d", k), 32'(bus.mem_wen), 0);
      chk($sformatf("wd.rv1_%0d", k), 32'(bus.m1_rvalid), 0);
    end
    chk("wd.mem3", mem[3], 32'h1000_0003);

    // reset during ACCESS of a store
    @(negedge clk);
    set0(1, 1, A8, 32'hCAFEF00D, 0);
    #1 chk("ra.rdy0", 32'(bus.m0_ready), 1);
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    #1 chk("ra.wen1", 32'(bus.mem_wen), 1);
    rst = 1'b1;
    #1 chk("ra.wen0", 32'(bus.mem_wen), 0);
    chk("ra.addr", bus.mem_addr, 0);
    chk("ra.wdata", bus.mem_wdata, 0);
    chk("ra.rd0", bus.m0_rdata, 0);
    chk("ra.rd1", bus.m1_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ra.rv0a", 32'(bus.m0_rvalid), 0);
    @(negedge clk);
    set0(1, 0, A8, 0, 0);
    set1(1, 0, A8, 0, 0);
    #1 chk("ra.rdy0b", 32'(bus.m0_ready), 1);
    chk("ra.rdy1b", 32'(bus.m1_ready), 0);
    @(negedge clk);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    #1 chk("ra.rv0b", 32'(bus.m0_rvalid), 0);
    @(negedge clk);
    #1 chk("ra.rv0c", 32'(bus.m0_rvalid), 1);
    chk("ra.rd0c", bus.m0_rdata, 32'h1000_0002);
    chk("ra.rv1c", 32'(bus.m1_rvalid), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  ADDR_W, 32, address width
  DATA_W, 32, data width
REQ-002 Ports SHALL be, one per line, as name  direction  width  meaning:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  m0_valid  in  1  requester 0 (CPU load/store) request
  m0_ready  out  1  requester 0 accept
  m0_addr  in  ADDR_W  byte address
  m0_wdata  in  DATA_W  store data
  m0_wen  in  1  1 = store, 0 = load
  m0_width  in  2  00 word, 01 half, 10 byte, 11 word
  m0_rvalid  out  1  response pulse
  m0_rdata  out  DATA_W  load data
  m1_valid, m1_ready, m1_addr, m1_wdata, m1_wen, m1_width, m1_rvalid, m1_rdata  same as m0 (requester 1, loader/debug)
  mem_addr  out  ADDR_W  to data memory
  mem_wdata  out  DATA_W  to data memory
  mem_wen  out  1  to data memory write enable
  mem_width  out  2  to data memory DataWidth
  mem_dout  in  DATA_W  from data memory, combinational read
  err  out  1  misaligned-access pulse
REQ-003 clk and rst SHALL be the only clock and reset; reset is asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on accept, ACCESS->RESP always, and RESP->IDLE always.
REQ-005 mX_ready SHALL be asserted only in IDLE and only for the arbitration winner; accept occurs on mX_valid && mX_ready in the same cycle.
REQ-006 On single valid, that requester SHALL win; on simultaneous valid, the holder of the round-robin priority SHALL win.
REQ-007 Priority SHALL move to the non-granted requester on every accept.
REQ-008 On accept, addr, wdata, wen, width and requester id SHALL be registered; mem_* SHALL be driven from these registers.
REQ-009 mem_wen SHALL be 1 for exactly the ACCESS cycle of a store; it SHALL be 0 in IDLE and RESP.
REQ-010 At the end of ACCESS, mem_dout SHALL be captured; loads return it unmodified, stores return 0.
REQ-011 mX_rvalid SHALL pulse for one cycle in RESP for the granted requester only; mX_rdata SHALL hold its last value otherwise.
REQ-012 Latency SHALL be accept cycle to rvalid = 2 cycles; peak throughput SHALL be one transaction per 3 cycles.
REQ-013 Requesters SHALL hold valid and all fields stable until ready; withdrawing valid before ready SHALL be legal and cause no access.

Reset
REQ-014 On rst: state IDLE, priority m0, mem_wen 0, mem_addr/mem_wdata 0, mem_width 00, all ready/rvalid/rdata 0, err 0; all of this SHALL take effect immediately, including mid-ACCESS (the store is dropped).

Configuration
REQ-015 With DMEM_ARB_ALIGN_CHK_EN defined, a word access with addr[1:0]!=0 or a half access with addr[0]!=0 SHALL suppress mem_wen, return rdata 0, and pulse err with rvalid.
REQ-016 Without DMEM_ARB_ALIGN_CHK_EN, the err port SHALL remain and be tied 0, and misaligned accesses SHALL proceed unchecked.

Structure
REQ-017 Package dmem_arb_pkg SHALL hold the state enum and width constants WIDTH_WORD=00, WIDTH_HALF=01, WIDTH_BYTE=10.
REQ-018 The two-way round-robin pick plus priority flop SHALL be sub-module rr_arb2.

Verification
REQ-019 m0 store addr 0x10000, wdata 0xDEADBEEF, width 00 -> mem_wen 1 for one cycle in ACCESS; a following m0 load of 0x10000 returns m0_rdata 0xDEADBEEF with m0_rvalid 2 cycles after accept.
REQ-020 m0 and m1 both valid from reset, held for 4 transactions -> grants m0, m1, m0, m1; the non-granted ready stays 0.
REQ-021 m1 byte store 0x000000AB to 0x10004 -> mem_width 10 and mem_wdata 0x000000AB; m1_rvalid pulses with m1_rdata 0; m0_rvalid stays 0.
REQ-022 rst asserted during ACCESS of a store to 0x10008 -> mem_wen falls at once, no rvalid, a load of 0x10008 returns its prior contents, and the next grant goes to m0.
REQ-023 With DMEM_ARB_ALIGN_CHK_EN, word store to 0x10002 -> mem_wen never 1, err and m0_rvalid pulse together, m0_rdata 0; without the macro -> write occurs and err stays 0.
